// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage master for an SRAM-like data bus (req/addr_ok, then data_ok).
// It returns aligned, extended load data, or passes the ALU result through, toward MEM/WB.
// It requests a pipeline stall while a bus transaction is outstanding.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_write_mem,
    input  logic              i_mem_to_regfile,
    input  logic [31:0]       i_da,
    input  logic [31:0]       i_db,
    input  logic [7:0]        i_mem_control,
    input  logic              i_hold,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic              o_stallreq,
    output logic [31:0]       o_wb_data,
    output logic              o_addr_err,
    output logic [31:0]       o_badvaddr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic              req_q;
    logic              wr_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [31:0]       da_q;
    logic [DATA_W-1:0] wdata_q;
    logic [31:0]       wb_q;
    logic              err_seen_q;
    logic [31:0]       err_da_q;
    logic [4:0]        err_key_q;

    logic              access;
    logic [1:0]        size_in;
    logic              misaligned;
    logic              bad_now;
    logic              same_fault;
    logic              issue;
    logic              capture;
    logic [DATA_W-1:0] wdata_in;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [31:0]       load_val;
    logic [31:0]       result;
    logic              unused_ctrl;

    assign unused_ctrl = ^i_mem_control[7:3];

    // Decode the incoming access: size (11 is treated as word), alignment, and whether to issue.
    always_comb begin
        access     = i_write_mem | i_mem_to_regfile;
        size_in    = (i_mem_control[1:0] == 2'b11) ? 2'b10 : i_mem_control[1:0];
        misaligned = ((size_in == 2'b10) && (i_da[1:0] != 2'b00)) ||
                     ((size_in == 2'b01) && i_da[0]);
        bad_now    = (state_q == IDLE) && access && misaligned;
        issue      = (state_q == IDLE) && access && !misaligned;
        same_fault = err_seen_q && (err_da_q == i_da) &&
                     (err_key_q == {i_write_mem, i_mem_to_regfile, i_mem_control[2:0]});
        capture    = ((state_q == REQ) && data_addr_ok && data_data_ok) ||
                     ((state_q == WAIT) && data_data_ok);
    end

    // Replicate the store data into every byte lane covered by the access size.
    always_comb begin
        wdata_in = i_db;
        case (size_in)
            2'b00:   wdata_in = {4{i_db[7:0]}};
            2'b01:   wdata_in = {2{i_db[15:0]}};
            default: wdata_in = i_db;
        endcase
    end

    // Select the addressed lane of the read data and sign/zero extend it.
    always_comb begin
        load_byte = data_rdata[7:0];
        case (da_q[1:0])
            2'b00:   load_byte = data_rdata[7:0];
            2'b01:   load_byte = data_rdata[15:8];
            2'b10:   load_byte = data_rdata[23:16];
            default: load_byte = data_rdata[31:24];
        endcase
        load_half = da_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (size_q)
            2'b00:   load_val = {{24{~unsigned_q & load_byte[7]}}, load_byte};
            2'b01:   load_val = {{16{~unsigned_q & load_half[15]}}, load_half};
            default: load_val = data_rdata;
        endcase
        result = wr_q ? da_q : load_val;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the bus handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (issue) state_d = REQ;
            REQ: begin
                if (data_addr_ok) begin
                    state_d = data_data_ok ? DONE : WAIT;
                end
            end
            WAIT: if (data_data_ok) state_d = DONE;
            DONE: if (!i_hold) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields, captured result and misalignment bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            da_q       <= '0;
            wdata_q    <= '0;
            wb_q       <= '0;
            err_seen_q <= 1'b0;
            err_da_q   <= '0;
            err_key_q  <= '0;
        end else begin
            if (issue) begin
                req_q      <= 1'b1;
                wr_q       <= i_write_mem;
                size_q     <= size_in;
                unsigned_q <= i_mem_control[2];
                da_q       <= i_da;
                wdata_q    <= wdata_in;
            end else if ((state_q == REQ) && data_addr_ok) begin
                req_q <= 1'b0;
            end
            if (capture) begin
                wb_q <= result;
            end
            // Remember the faulting inputs so a held misaligned access pulses only once.
            err_seen_q <= bad_now;
            if (bad_now) begin
                err_da_q  <= i_da;
                err_key_q <= {i_write_mem, i_mem_to_regfile, i_mem_control[2:0]};
            end
        end
    end

    assign data_req   = req_q;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = da_q[ADDR_W-1:0];
    assign data_wdata = wdata_q;

    // Combinational outputs are gated by the reset input so they read as reset values
    // while reset is held, even though an access may still be presented.
    always_comb begin
        o_stallreq = reset && (issue || (state_q == REQ) || (state_q == WAIT));
        o_wb_data  = '0;
        if (reset) begin
            o_wb_data = (state_q == IDLE) ? i_da : wb_q;
        end
        o_addr_err = reset && bad_now && !same_fault;
        o_badvaddr = o_addr_err ? i_da : '0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard queue of expected MEM/WB results.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_write_mem = 1'b0;
    logic        i_mem_to_regfile = 1'b0;
    logic [31:0] i_da = '0;
    logic [31:0] i_db = '0;
    logic [7:0]  i_mem_control = '0;
    logic        i_hold = 1'b0;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        o_stallreq;
    logic [31:0] o_wb_data;
    logic        o_addr_err;
    logic [31:0] o_badvaddr;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .i_write_mem(i_write_mem),
        .i_mem_to_regfile(i_mem_to_regfile),
        .i_da(i_da),
        .i_db(i_db),
        .i_mem_control(i_mem_control),
        .i_hold(i_hold),
        .data_req(data_req),
        .data_wr(data_wr),
        .data_size(data_size),
        .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .o_stallreq(o_stallreq),
        .o_wb_data(o_wb_data),
        .o_addr_err(o_addr_err),
        .o_badvaddr(o_badvaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one aligned access in IDLE and play the slave side of the handshake.
    // addr_ok is given in cycle aok, data_ok in cycle dok (cycle 0 = presentation cycle).
    task automatic run_access(input string name, input logic wr, input logic rd,
                              input logic [31:0] da, input logic [31:0] db, input logic [7:0] ctrl,
                              input int aok, input int dok, input logic [31:0] rdata,
                              input int hold_n, input logic [31:0] exp_wb,
                              input logic [1:0] exp_size, input logic [31:0] exp_wdata);
        int hs;
        logic [31:0] exp;
        hs = 0;
        i_write_mem = wr;
        i_mem_to_regfile = rd;
        i_da = da;
        i_db = db;
        i_mem_control = ctrl;
        i_hold = 1'b0;
        exp_q.push_back(exp_wb);
        #1;
        check({name, "_stall_c0"}, 32'(o_stallreq), 32'd1);
        check({name, "_noreq_c0"}, 32'(data_req), 32'd0);
        for (int c = 1; c <= dok; c++) begin
            step();
            data_addr_ok = (c == aok);
            data_data_ok = (c == dok);
            data_rdata   = (c == dok) ? rdata : 32'h0;
            #1;
            check($sformatf("%s_req_c%0d", name, c), 32'(data_req), 32'(c <= aok));
            check($sformatf("%s_stall_c%0d", name, c), 32'(o_stallreq), 32'd1);
            if (c == 1) begin
                check({name, "_wr"}, 32'(data_wr), 32'(wr));
                check({name, "_size"}, 32'(data_size), 32'(exp_size));
                check({name, "_addr"}, data_addr, da);
                if (wr) check({name, "_wdata"}, data_wdata, exp_wdata);
            end
            @(negedge clk);
            if (data_req && data_addr_ok) hs++;
        end
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        i_hold = (hold_n > 0);
        #1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check({name, "_wb_done"}, o_wb_data, exp);
        check({name, "_stall_done"}, 32'(o_stallreq), 32'd0);
        check({name, "_req_done"}, 32'(data_req), 32'd0);
        check({name, "_handshakes"}, 32'(hs), 32'd1);
        for (int h = 1; h <= hold_n; h++) begin
            step();
            if (h == hold_n) i_hold = 1'b0;
            #1;
            check($sformatf("%s_hold_wb%0d", name, h), o_wb_data, exp);
            check($sformatf("%s_hold_stall%0d", name, h), 32'(o_stallreq), 32'd0);
            check($sformatf("%s_hold_req%0d", name, h), 32'(data_req), 32'd0);
        end
        step();
        i_write_mem = 1'b0;
        i_mem_to_regfile = 1'b0;
        i_da = 32'h13570000 ^ da;
        #1;
        check({name, "_idle_pass"}, o_wb_data, 32'h13570000 ^ da);
        check({name, "_idle_req"}, 32'(data_req), 32'd0);
        check({name, "_idle_stall"}, 32'(o_stallreq), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_stall", 32'(o_stallreq), 32'd0);
        check("rst_wb", o_wb_data, 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_err", 32'(o_addr_err), 32'd0);
        step();
        reset = 1'b1;
        step();

        // Loads: word, signed/unsigned byte, signed half; store cases follow.
        run_access("ldw", 1'b0, 1'b1, 32'h80001004, 32'h0, 8'h02, 1, 3, 32'hDEADBEEF, 0,
                   32'hDEADBEEF, 2'b10, 32'h0);
        run_access("lbs", 1'b0, 1'b1, 32'h80001003, 32'h0, 8'h00, 1, 2, 32'h80FF1234, 0,
                   32'hFFFFFF80, 2'b00, 32'h0);
        run_access("lbu", 1'b0, 1'b1, 32'h80001003, 32'h0, 8'h04, 2, 4, 32'h80FF1234, 0,
                   32'h00000080, 2'b00, 32'h0);
        run_access("lhs", 1'b0, 1'b1, 32'h80001002, 32'h0, 8'h01, 1, 1, 32'h80FF1234, 0,
                   32'hFFFF80FF, 2'b01, 32'h0);
        run_access("sh", 1'b1, 1'b0, 32'h80001002, 32'h0000ABCD, 8'h01, 1, 2, 32'h0, 0,
                   32'h80001002, 2'b01, 32'hABCDABCD);
        run_access("sb", 1'b1, 1'b0, 32'h80001001, 32'h1234565A, 8'h00, 2, 3, 32'h0, 0,
                   32'h80001001, 2'b00, 32'h5A5A5A5A);
        run_access("swboth", 1'b1, 1'b1, 32'h80003000, 32'hCAFEF00D, 8'h02, 1, 2, 32'h0, 0,
                   32'h80003000, 2'b10, 32'hCAFEF00D);
        run_access("ldhold", 1'b0, 1'b1, 32'h80002000, 32'h0, 8'h03, 1, 1, 32'h12345678, 3,
                   32'h12345678, 2'b10, 32'h0);
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_empty: observed %0d entries expected 0", exp_q.size());
        end

        // Misaligned word load: single pulse, no request, no stall.
        i_mem_to_regfile = 1'b1;
        i_da = 32'h80001002;
        i_mem_control = 8'h02;
        #1;
        check("mis_err", 32'(o_addr_err), 32'd1);
        check("mis_bad", o_badvaddr, 32'h80001002);
        check("mis_stall", 32'(o_stallreq), 32'd0);
        step();
        check("mis_err_held", 32'(o_addr_err), 32'd0);
        check("mis_req", 32'(data_req), 32'd0);
        i_da = 32'h80001005;
        i_mem_control = 8'h01;
        #1;
        check("mish_err", 32'(o_addr_err), 32'd1);
        check("mish_bad", o_badvaddr, 32'h80001005);
        step();
        check("mish_req", 32'(data_req), 32'd0);
        i_mem_to_regfile = 1'b0;
        i_da = 32'h0;
        step();

        // Reset asserted while waiting for data_ok, then a late data_ok.
        i_mem_to_regfile = 1'b1;
        i_da = 32'h80004000;
        i_mem_control = 8'h02;
        step();
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        #1;
        check("rw_stall_wait", 32'(o_stallreq), 32'd1);
        reset = 1'b0;
        #1;
        check("rw_req", 32'(data_req), 32'd0);
        check("rw_stall", 32'(o_stallreq), 32'd0);
        check("rw_wb", o_wb_data, 32'd0);
        check("rw_addr", data_addr, 32'd0);
        check("rw_err", 32'(o_addr_err), 32'd0);
        i_mem_to_regfile = 1'b0;
        i_da = 32'h0;
        step();
        reset = 1'b1;
        data_data_ok = 1'b1;
        data_rdata = 32'hBADBAD00;
        #1;
        check("late_stall", 32'(o_stallreq), 32'd0);
        step();
        data_data_ok = 1'b0;
        #1;
        check("late_req", 32'(data_req), 32'd0);
        check("late_stall2", 32'(o_stallreq), 32'd0);
        check("late_wb", o_wb_data, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
